// File: rtl/vga_tile_pkg.sv
// Shared types for the tile-grid VGA renderer: RGB222 colour, fixed
// palette and the clear-sweep FSM state encoding.
package vga_tile_pkg;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t PAL_BLACK = 6'b00_00_00;
    localparam rgb_t PAL_WHITE = 6'b11_11_11;
    localparam rgb_t PAL_RED   = 6'b11_00_00;
    localparam rgb_t PAL_GREEN = 6'b00_11_00;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    // Map a 2-bit palette index to its RGB222 colour.
    function automatic rgb_t pal_lookup(input logic [1:0] idx);
        case (idx)
            2'd0:    return PAL_BLACK;
            2'd1:    return PAL_WHITE;
            2'd2:    return PAL_RED;
            default: return PAL_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/tile_ram_dp.sv
// Simple dual-port cell RAM: one synchronous write port, one synchronous
// read port. A read of the address being written in the same cycle
// returns the old contents.
module tile_ram_dp #(
    parameter int AW = 8,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    // Write port and registered read port share the pixel clock.
    // NOTE: the array has no reset so it maps onto block RAM; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_tile_display.sv
// Tile-grid VGA renderer: GRID_W x GRID_H cells of BPP bits drawn as
// (1<<CELL_LOG2)-pixel squares at (X0, Y0), border colour elsewhere.
// Pixel latency is two clocks after the coordinates are sampled.
// Optional feature macro VGA_TILE_CURSOR_EN adds a blinking cursor cell.
module vga_tile_display
    import vga_tile_pkg::*;
#(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int CELL_LOG2  = 4,
    parameter int X0         = 192,
    parameter int Y0         = 112,
    parameter int BPP        = 2,
    parameter int BORDER_IDX = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                xcoor,
    input  logic [9:0]                ycoor,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(GRID_W)-1:0] wr_x,
    input  logic [$clog2(GRID_H)-1:0] wr_y,
    input  logic [BPP-1:0]            wr_data,
`ifdef VGA_TILE_CURSOR_EN
    input  logic [$clog2(GRID_W)-1:0] cur_x,
    input  logic [$clog2(GRID_H)-1:0] cur_y,
`endif
    input  logic                      clear_req,
    output logic                      busy,
    output logic [1:0]                red,
    output logic [1:0]                green,
    output logic [1:0]                blue
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int AW = XW + YW;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(GRID_W * GRID_H - 1);
    localparam logic [10:0]   X_LO       = 11'(X0);
    localparam logic [10:0]   X_HI       = 11'(X0 + (GRID_W << CELL_LOG2));
    localparam logic [10:0]   Y_LO       = 11'(Y0);
    localparam logic [10:0]   Y_HI       = 11'(Y0 + (GRID_H << CELL_LOG2));
    localparam logic [1:0]    BORDER_SEL = 2'(BORDER_IDX);

    state_t          state;
    logic [AW-1:0]   addr;
    logic            wr_fire;
    logic            ram_we;
    logic [AW-1:0]   ram_wa;
    logic [BPP-1:0]  ram_wd;

    logic [10:0]     x_off, y_off;
    logic [XW-1:0]   cell_x;
    logic [YW-1:0]   cell_y;
    logic            in_grid;
    logic [AW-1:0]   rd_addr_q;
    logic            in_grid_q, in_grid_q2;
    logic [BPP-1:0]  rd_data;
    logic [1:0]      pal_idx;
    logic            cur_hit_d, cur_hit_q, cur_hit_q2;
    logic            blink;
    rgb_t            px, colour_q;

    assign wr_fire = wr_valid & wr_ready;

    // Clear-sweep FSM with registered busy / wr_ready.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            addr     <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_req) begin
                        addr <= '0;
                    end else if (addr == ADDR_LAST) begin
                        state    <= IDLE;
                        addr     <= '0;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        addr     <= '0;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    addr  <= '0;
                end
            endcase
        end
    end

    // RAM write port: sweep zeroes while clearing, game writes otherwise.
    // NOTE: every output gets a value on every path so no latch is inferred.
    always_comb begin
        ram_we = (state == CLEAR) | wr_fire;
        ram_wa = (state == CLEAR) ? addr : {wr_y, wr_x};
        ram_wd = (state == CLEAR) ? '0 : wr_data;
    end

    tile_ram_dp #(
        .AW (AW),
        .DW (BPP)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_wa),
        .wr_data (ram_wd),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data)
    );

    // Grid hit test and cell coordinates for the current pixel.
    always_comb begin
        x_off   = {1'b0, xcoor} - X_LO;
        y_off   = {1'b0, ycoor} - Y_LO;
        cell_x  = XW'(x_off >> CELL_LOG2);
        cell_y  = YW'(y_off >> CELL_LOG2);
        in_grid = ({1'b0, xcoor} >= X_LO) && ({1'b0, xcoor} < X_HI) &&
                  ({1'b0, ycoor} >= Y_LO) && ({1'b0, ycoor} < Y_HI);
    end

`ifdef VGA_TILE_CURSOR_EN
    logic [4:0] frame_cnt;

    assign cur_hit_d = in_grid && (cell_x == cur_x) && (cell_y == cur_y);

    // Frame counter: blink flips every 32 frames, a frame starts at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (xcoor == 10'd0 && ycoor == 10'd0) begin
            frame_cnt <= frame_cnt + 5'd1;
            if (frame_cnt == 5'd31) begin
                blink <= ~blink;
            end
        end
    end
`else
    assign cur_hit_d = 1'b0;
    assign blink     = 1'b0;
`endif

    // Stage 1: RAM read address, grid flag and cursor hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            in_grid_q <= 1'b0;
            cur_hit_q <= 1'b0;
        end else begin
            rd_addr_q <= in_grid ? {cell_y, cell_x} : '0;
            in_grid_q <= in_grid;
            cur_hit_q <= cur_hit_d;
        end
    end

    // Stage 2 side-band: flags travel alongside the RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_grid_q2 <= 1'b0;
            cur_hit_q2 <= 1'b0;
        end else begin
            in_grid_q2 <= in_grid_q;
            cur_hit_q2 <= cur_hit_q;
        end
    end

    if (BPP == 1) begin : g_bpp1
        assign pal_idx = {1'b0, rd_data};
    end else begin : g_bpp2
        assign pal_idx = rd_data;
    end

    // Palette lookup, border substitution and cursor inversion.
    always_comb begin
        px = in_grid_q2 ? pal_lookup(pal_idx) : pal_lookup(BORDER_SEL);
        if (cur_hit_q2 && blink) begin
            px = rgb_t'(~px);
        end
    end

    // Output colour register.
    always_ff @(posedge clk) begin
        if (rst) begin
            colour_q <= PAL_BLACK;
        end else begin
            colour_q <= px;
        end
    end

    assign red   = colour_q.r;
    assign green = colour_q.g;
    assign blue  = colour_q.b;

endmodule

// File: tb/tb_vga_tile_display.sv
// Directed testbench for vga_tile_display (default build, 16x16 grid of
// 16-pixel cells at (192,112), 2 bits per cell, white border).
module tb_vga_tile_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] xcoor = '0;
    logic [9:0] ycoor = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_x = '0;
    logic [3:0] wr_y = '0;
    logic [1:0] wr_data = '0;
    logic       clear_req = 1'b0;
    logic       busy;
    logic [1:0] red, green, blue;
    logic [5:0] rgb;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] model [16][16];

    always #5 clk = ~clk;

    assign rgb = {red, green, blue};

    vga_tile_display dut (
        .clk       (clk),
        .rst       (rst),
        .xcoor     (xcoor),
        .ycoor     (ycoor),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .clear_req (clear_req),
        .busy      (busy),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    function automatic logic [5:0] pal(input logic [1:0] i);
        case (i)
            2'd0:    return 6'b000000;
            2'd1:    return 6'b111111;
            2'd2:    return 6'b110000;
            default: return 6'b001100;
        endcase
    endfunction

    function automatic logic [5:0] exp_rgb(input int x, input int y);
        if (x >= 192 && x < 448 && y >= 112 && y < 368)
            return pal(model[(y - 112) / 16][(x - 192) / 16]);
        return pal(2'd1);
    endfunction

    task automatic model_zero();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                model[r][c] = 2'd0;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one coordinate and return the colour two clocks after it is sampled.
    task automatic probe(input int x, input int y, output logic [5:0] got);
        xcoor = 10'(x);
        ycoor = 10'(y);
        repeat (3) tick();
        got = rgb;
    endtask

    task automatic do_write(input int x, input int y, input logic [1:0] d, output logic acc);
        wr_x     = 4'(x);
        wr_y     = 4'(y);
        wr_data  = d;
        wr_valid = 1'b1;
        acc      = wr_ready;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tests_run++;
        if (rgb !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_rgb: got %b expected %b", rgb, 6'b000000);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 1", busy);
        end
        tests_run++;
        if (wr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wr_ready: got %b expected 0", wr_ready);
        end
    endtask

    task automatic test_clear_after_reset();
        int  cnt;
        bit  busy_bad;
        rst      = 1'b0;
        cnt      = 0;
        busy_bad = 1'b0;
        while (cnt < 1000) begin
            tick();
            cnt++;
            if (wr_ready === 1'b1) break;
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        model_zero();
        tests_run++;
        if (cnt !== 256) begin
            tests_failed++;
            $display("FAIL clear_len_after_reset: got %0d cycles expected 256", cnt);
        end
        tests_run++;
        if (busy_bad) begin
            tests_failed++;
            $display("FAIL busy_during_clear: got 0 expected 1");
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_after_clear: got %b expected 0", busy);
        end
    endtask

    // Stream whole rows one pixel per clock and compare against the model.
    task automatic test_frame_scan();
        int         rows [7];
        int         y;
        bit         bad;
        int         bx;
        logic [5:0] bgot, bexp;
        rows = '{0, 111, 112, 192, 367, 368, 479};
        for (int r = 0; r < 7; r++) begin
            y   = rows[r];
            bad = 1'b0;
            bx  = 0;
            bgot = '0;
            bexp = '0;
            for (int j = 0; j < 643; j++) begin
                if (j >= 3 && !bad && rgb !== exp_rgb(j - 3, y)) begin
                    bad  = 1'b1;
                    bx   = j - 3;
                    bgot = rgb;
                    bexp = exp_rgb(j - 3, y);
                end
                if (j < 640) begin
                    xcoor = 10'(j);
                    ycoor = 10'(y);
                end
                tick();
            end
            tests_run++;
            if (bad) begin
                tests_failed++;
                $display("FAIL scan_row_%0d at x=%0d: got %b expected %b", y, bx, bgot, bexp);
            end
        end
    endtask

    task automatic test_write_pixel();
        logic       acc;
        logic [5:0] got;
        do_write(3, 5, 2'd2, acc);
        model[5][3] = 2'd2;
        tests_run++;
        if (acc !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_accept: got %b expected 1", acc);
        end
        xcoor = 10'd0;
        ycoor = 10'd0;
        repeat (4) tick();
        xcoor = 10'd247;
        ycoor = 10'd192;
        tick();
        xcoor = 10'd0;
        ycoor = 10'd0;
        tick();
        tests_run++;
        if (rgb !== 6'b111111) begin
            tests_failed++;
            $display("FAIL latency_edge1: got %b expected %b", rgb, 6'b111111);
        end
        tick();
        tests_run++;
        if (rgb !== 6'b110000) begin
            tests_failed++;
            $display("FAIL latency_edge2_red: got %b expected %b", rgb, 6'b110000);
        end
        tick();
        tests_run++;
        if (rgb !== 6'b111111) begin
            tests_failed++;
            $display("FAIL latency_edge3: got %b expected %b", rgb, 6'b111111);
        end
        probe(231, 192, got);
        tests_run++;
        if (got !== 6'b000000) begin
            tests_failed++;
            $display("FAIL neighbour_2_5: got %b expected %b", got, 6'b000000);
        end
    endtask

    // Back-to-back writes to the corner cells, then probe the grid edges.
    task automatic test_boundaries();
        int         px [6];
        int         py [6];
        logic [5:0] ex [6];
        logic [5:0] got;
        wr_valid = 1'b1;
        wr_x = 4'd0;  wr_y = 4'd0;  wr_data = 2'd2;
        tick();
        wr_x = 4'd15; wr_y = 4'd15; wr_data = 2'd3;
        tick();
        wr_valid = 1'b0;
        model[0][0]   = 2'd2;
        model[15][15] = 2'd3;
        px = '{191, 448, 192, 447, 192, 447};
        py = '{112, 112, 112, 367, 111, 368};
        ex = '{6'b111111, 6'b111111, 6'b110000, 6'b001100, 6'b111111, 6'b111111};
        for (int i = 0; i < 6; i++) begin
            probe(px[i], py[i], got);
            tests_run++;
            if (got !== ex[i]) begin
                tests_failed++;
                $display("FAIL boundary_(%0d,%0d): got %b expected %b", px[i], py[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_wr_during_clear();
        int         cnt;
        logic [5:0] got;
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        wr_x     = 4'd7;
        wr_y     = 4'd7;
        wr_data  = 2'd3;
        wr_valid = 1'b1;
        cnt      = 0;
        while (cnt < 1000 && wr_ready !== 1'b1) begin
            tick();
            cnt++;
        end
        tick();
        wr_valid = 1'b0;
        model_zero();
        model[7][7] = 2'd3;
        tests_run++;
        if (cnt !== 256) begin
            tests_failed++;
            $display("FAIL wr_ready_wait: got %0d cycles expected 256", cnt);
        end
        probe(309, 229, got);
        tests_run++;
        if (got !== 6'b001100) begin
            tests_failed++;
            $display("FAIL held_write_lands: got %b expected %b", got, 6'b001100);
        end
        probe(192, 112, got);
        tests_run++;
        if (got !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_recleared_0_0: got %b expected %b", got, 6'b000000);
        end
    endtask

    task automatic test_clear_collision();
        int         cnt;
        logic [5:0] got;
        wr_x      = 4'd9;
        wr_y      = 4'd2;
        wr_data   = 2'd3;
        wr_valid  = 1'b1;
        clear_req = 1'b1;
        tick();
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_enters_clear: got busy=%b wr_ready=%b expected busy=1 wr_ready=0", busy, wr_ready);
        end
        cnt = 0;
        while (cnt < 1000 && busy === 1'b1) begin
            tick();
            cnt++;
        end
        model_zero();
        tests_run++;
        if (cnt !== 256) begin
            tests_failed++;
            $display("FAIL collision_clear_len: got %0d cycles expected 256", cnt);
        end
        probe(339, 147, got);
        tests_run++;
        if (got !== 6'b000000) begin
            tests_failed++;
            $display("FAIL collision_cell_zero: got %b expected %b", got, 6'b000000);
        end
        probe(309, 229, got);
        tests_run++;
        if (got !== 6'b000000) begin
            tests_failed++;
            $display("FAIL collision_old_cell_zero: got %b expected %b", got, 6'b000000);
        end
    endtask

    task automatic test_clear_restart();
        int         cnt;
        logic       acc;
        logic [5:0] got;
        do_write(15, 15, 2'd3, acc);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        probe(447, 367, got);
        tests_run++;
        if (got !== 6'b001100) begin
            tests_failed++;
            $display("FAIL display_during_clear: got %b expected %b", got, 6'b001100);
        end
        repeat (97) tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_at_cycle_100: got %b expected 1", busy);
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (cnt < 1000 && busy === 1'b1) begin
            tick();
            cnt++;
        end
        model_zero();
        tests_run++;
        if (cnt !== 256) begin
            tests_failed++;
            $display("FAIL restart_clear_len: got %0d cycles expected 256", cnt);
        end
        probe(447, 367, got);
        tests_run++;
        if (got !== 6'b000000) begin
            tests_failed++;
            $display("FAIL restart_cleared_15_15: got %b expected %b", got, 6'b000000);
        end
    endtask

    initial begin
        model_zero();
        test_reset();
        test_clear_after_reset();
        test_frame_scan();
        test_write_pixel();
        test_boundaries();
        test_frame_scan();
        test_wr_during_clear();
        test_clear_collision();
        test_clear_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_tile_display.md
# vga_tile_display

Parametrised tile-grid VGA renderer: holds a GRID_W x GRID_H array of BPP-bit cells in on-chip dual-port RAM and maps each cell to a CELL_PX x CELL_PX square placed at (X0, Y0) on the VGA frame. Pixels inside the grid are coloured through a fixed palette; pixels outside the grid get the border colour. It sits between the VGA timing generator (xcoor/ycoor) and the pin driver, and takes cell updates from game logic over a valid/ready write port. A sweep FSM clears the grid after reset or on request.

## Interface
- GRID_W, 16, cells per row (power of 2, 2..64)
- GRID_H, 16, cells per column (power of 2, 2..64)
- CELL_LOG2, 4, log2 of cell edge in pixels (cell = 16 px)
- X0, 192, left pixel column of grid
- Y0, 112, top pixel row of grid
- BPP, 2, bits per cell (1 or 2); palette index
- BORDER_IDX, 1, palette index shown outside grid
- clk  in  1  pixel clock; one clock domain; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- xcoor  in  10  current pixel column
- ycoor  in  10  current pixel row
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_x  in  $clog2(GRID_W)  cell column
- wr_y  in  $clog2(GRID_H)  cell row
- wr_data  in  BPP  cell value
- clear_req  in  1  one-cycle pulse: restart full clear
- busy  out  1  high while clear sweep runs
- red, green, blue  out  2 each  colour output

## Operation
- FSM states CLEAR, IDLE. Reset -> CLEAR with sweep address 0.
- CLEAR: writes 0 to cell (addr), addr increments each cycle, row-major (addr = y*GRID_W + x); after addr = GRID_W*GRID_H-1 goes to IDLE. busy=1, wr_ready=0.
- IDLE: wr_ready=1, busy=0; handshake writes wr_data to (wr_x, wr_y) at that edge. clear_req in IDLE -> CLEAR, addr 0; clear_req in CLEAR restarts sweep at 0. clear_req and wr_valid in same IDLE cycle: write accepted, then clear (clear wins the final state).
- Pixel path: in_grid = X0 <= xcoor < X0+(GRID_W<<CELL_LOG2) and likewise y. Cell = (xcoor-X0)>>CELL_LOG2, (ycoor-Y0)>>CELL_LOG2; subtraction only used when in_grid.
- Colour = palette[cell value] if in_grid else palette[BORDER_IDX]. Palette (6-bit RGB222): 0 black 000000, 1 white 111111, 2 red 110000, 3 green 001100. BPP=1 uses entries 0/1.
- Display reads continue during CLEAR (shows partially cleared grid; no blanking).

## Timing
- Reset values: red/green/blue=0, wr_ready=0, busy=1, addr=0.
- Pixel latency exactly 2 cycles: coordinates sampled at edge N -> colour on outputs after edge N+2. Stage 1 registers RAM address and in_grid; stage 2 registers RAM data through palette. in_grid is pipelined alongside data.
- Write-to-display: cell written at edge N is visible for read addresses presented at edge N+1 or later (read-after-write to same address in same cycle returns old data).
- Clear duration: GRID_W*GRID_H cycles (256 default); wr_ready rises on the cycle after the final clear write.
- Reset mid-sweep or mid-write: restarts CLEAR at addr 0; pipeline registers zeroed.

## Configuration
- VGA_TILE_CURSOR_EN defined: adds inputs cur_x, cur_y (widths as wr_x/wr_y); the cursor cell's colour is bitwise-inverted when blink=1. blink toggles every 32 frames; frame counted when xcoor==0 && ycoor==0; blink and 5-bit frame counter reset to 0. Cursor compare pipelined so latency stays 2.
- Undefined: no cursor ports, no counter, colour from palette only.

## Structure
- Package vga_tile_pkg: palette constants (PAL_BLACK, PAL_WHITE, PAL_RED, PAL_GREEN), RGB222 colour typedef, FSM state enum.
- Sub-module tile_ram_dp: one synchronous write port, one synchronous read port, GRID_W*GRID_H x BPP, no reset on contents.

## Test plan
- Reset 1 cycle, release -> busy=1 for 256 cycles, wr_ready=1 at cycle 257; scan full frame -> grid all black, border white.
- Write (3,5)=2 -> pixel (192+3*16+7, 112+5*16) red exactly 2 cycles after coordinate presented; neighbour (2,5) black.
- Coordinates (191,112) and (448,112) -> white border; (192,112) and (447,367) -> grid cells (0,0) and (15,15).
- wr_valid held during CLEAR -> no acceptance until wr_ready; write then lands; clear_req + wr_valid same cycle -> cell ends 0.
- clear_req at cycle 100 of sweep -> busy stays high another 256 cycles.
- VGA_TILE_CURSOR_EN: cursor at (0,0), cell value 1 -> output 000000 during frames 32-63, 111111 during frames 0-31.
